// File: rtl/mul16u_arb_pkg.sv
// Shared constants, the stage-register layout and a nibble helper for the
// shared approximate-multiplier arbiter.
package mul16u_arb_pkg;

  localparam int OP_W     = 16;
  localparam int PROD_W   = 32;
  localparam int NIB_LSB  = 12;
  localparam int NIB_W    = OP_W - NIB_LSB;
  localparam int DEF_NREQ = 4;
  // Tag storage is sized for the largest supported requester count (8).
  localparam int ID_MAX_W = 3;

  typedef struct packed {
    logic                valid;
    logic [OP_W-1:0]     a;
    logic [OP_W-1:0]     b;
    logic [ID_MAX_W-1:0] id;
  } stage_t;

  // Top nibble of an operand: the only bits the approximate core looks at.
  function automatic logic [NIB_W-1:0] top_nib(input logic [OP_W-1:0] v);
    return v[OP_W-1:NIB_LSB];
  endfunction

endpackage

// File: rtl/mul16u_rr_arbiter_if.sv
// Request/response bus between accelerator lanes and the shared multiplier.
//
// Handshake rule for both channels: a transfer happens on a rising edge where
// valid and ready are both 1. A source holds valid and its payload stable
// until that edge; valid never waits on ready. req_ready is one-hot or zero
// and may depend combinationally on req_valid and rsp_ready.
interface mul16u_rr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
);
  import mul16u_arb_pkg::*;

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*OP_W-1:0] req_a;
  logic [NREQ*OP_W-1:0] req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [PROD_W-1:0]    rsp_data;
  logic [ID_W-1:0]      rsp_id;
  logic [31:0]          op_count;
  // Round-robin pointer, exposed for observation only.
  logic [ID_W-1:0]      dbg_ptr;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, op_count, dbg_ptr
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, op_count, dbg_ptr
  );

endinterface

// File: rtl/mul16u_nib_core.sv
// Combinational approximate 16x16 unsigned multiplier: exact product of the
// top nibbles placed in the top byte, all other bits zero. Kept as its own
// module so another approximate variant can drop in with the same ports.
module mul16u_nib_core
  import mul16u_arb_pkg::*;
(
  input  logic [OP_W-1:0]   a_i,
  input  logic [OP_W-1:0]   b_i,
  output logic [PROD_W-1:0] o_o
);

  logic [2*NIB_W-1:0] nib_prod;
  logic               unused_lsbs;

  // Widen both nibbles first so the product keeps all eight bits.
  assign nib_prod    = {{NIB_W{1'b0}}, top_nib(a_i)} * {{NIB_W{1'b0}}, top_nib(b_i)};
  assign o_o         = {nib_prod, {(PROD_W - 2*NIB_W){1'b0}}};
  // The low operand bits are deliberately ignored by this core.
  assign unused_lsbs = ^{a_i[NIB_LSB-1:0], b_i[NIB_LSB-1:0]};

endmodule

// File: rtl/mul16u_rr_arbiter.sv
// Round-robin arbiter feeding a two-stage pipeline (operand register S1,
// output register S2) around one shared approximate multiplier core.
module mul16u_rr_arbiter
  import mul16u_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int ID_W = $clog2(NREQ)
) (
  input logic                clk,
  input logic                rst,
  mul16u_rr_arbiter_if.slave bus
);

  stage_t            s1_q, s1_d;
  logic              s2_valid_q, s2_valid_d;
  logic [PROD_W-1:0] s2_data_q, s2_data_d;
  logic [ID_W-1:0]   s2_id_q, s2_id_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [31:0]       op_count_q, op_count_d;

  logic              s1_adv, s2_adv;
  logic [NREQ-1:0]   grant;
  logic [ID_W-1:0]   grant_idx;
  logic [PROD_W-1:0] core_o;

  // First valid requester at or after ptr, wrapping modulo NREQ.
  function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] vld,
                                              input logic [ID_W-1:0] ptr);
    logic [NREQ-1:0] g;
    logic            found;
    int              idx;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && vld[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

  // Pipeline advance and grant. Reset blocks grants so no request is
  // acknowledged into a pipeline that is being cleared.
  always_comb begin
    s2_adv = !s2_valid_q || bus.rsp_ready;
    s1_adv = !s1_q.valid || s2_adv;
    grant  = (s1_adv && !rst) ? rr_pick(bus.req_valid, ptr_q) : '0;
  end

  // One-hot grant to index.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) grant_idx = ID_W'(i);
    end
  end

  mul16u_nib_core u_core (
    .a_i (s1_q.a),
    .b_i (s1_q.b),
    .o_o (core_o)
  );

  // Next state for S1, S2, the pointer and the completion counter.
  always_comb begin
    s1_d       = s1_q;
    ptr_d      = ptr_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_id_d    = s2_id_q;
    if (s1_adv) begin
      s1_d.valid = |grant;
      if (|grant) begin
        s1_d.a  = bus.req_a[int'(grant_idx)*OP_W +: OP_W];
        s1_d.b  = bus.req_b[int'(grant_idx)*OP_W +: OP_W];
        s1_d.id = ID_MAX_W'(grant_idx);
        ptr_d   = (int'(grant_idx) == NREQ-1) ? '0 : grant_idx + 1'b1;
      end
    end
    if (s2_adv) begin
      s2_valid_d = s1_q.valid;
      s2_data_d  = core_o;
      s2_id_d    = ID_W'(s1_q.id);
    end
    op_count_d = op_count_q + ((s2_valid_q && bus.rsp_ready) ? 32'd1 : 32'd0);
  end

  // State registers; reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_id_q    <= '0;
      ptr_q      <= '0;
      op_count_q <= '0;
    end else begin
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_id_q    <= s2_id_d;
      ptr_q      <= ptr_d;
      op_count_q <= op_count_d;
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = s2_valid_q;
  assign bus.rsp_data  = s2_data_q;
  assign bus.rsp_id    = s2_id_q;
  assign bus.op_count  = op_count_q;
  assign bus.dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_mul16u_rr_arbiter.sv
// Directed testbench for mul16u_rr_arbiter with four requesters.
module tb_mul16u_rr_arbiter;

  logic clk;
  logic rst;

  mul16u_rr_arbiter_if #(.NREQ(4), .ID_W(2)) bus ();

  mul16u_rr_arbiter #(.NREQ(4), .ID_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  int          n_checks;
  int          n_pass;
  logic [31:0] exp_count;
  logic [33:0] exp_q[$];

  // Per-requester operand table; products are hand-computed:
  // nibbles (1,2)->0x02, (2,3)->0x06, (3,4)->0x0C, (4,5)->0x14.
  logic [15:0] op_a [4];
  logic [15:0] op_b [4];
  logic [31:0] prod [4];

  task automatic load_table();
    for (int i = 0; i < 4; i++) begin
      bus.req_a[i*16 +: 16] = op_a[i];
      bus.req_b[i*16 +: 16] = op_b[i];
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.req_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b want 0000", bus.req_ready); else n_pass++;
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.rsp_data !== 32'h0) $display("FAIL reset_rsp_data: got %h want 00000000", bus.rsp_data); else n_pass++;
    n_checks++; if (bus.rsp_id !== 2'd0) $display("FAIL reset_rsp_id: got %0d want 0", bus.rsp_id); else n_pass++;
    n_checks++; if (bus.op_count !== 32'd0) $display("FAIL reset_op_count: got %0d want 0", bus.op_count); else n_pass++;
    n_checks++; if (bus.dbg_ptr !== 2'd0) $display("FAIL reset_ptr: got %0d want 0", bus.dbg_ptr); else n_pass++;
    rst = 1'b0;
    bus.req_valid = 4'b0000;
  endtask

  // One isolated operation from requester idx with rsp_ready held high.
  task automatic test_single_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                                input logic [31:0] exp_data);
    logic [3:0] v;
    v = 4'b0000;
    v[idx] = 1'b1;
    bus.req_a[idx*16 +: 16] = a;
    bus.req_b[idx*16 +: 16] = b;
    bus.req_valid = v;
    bus.rsp_ready = 1'b1;
    #1;
    n_checks++; if (bus.req_ready !== v) $display("FAIL single_req_ready: got %b want %b", bus.req_ready, v); else n_pass++;
    @(posedge clk); #1;
    bus.req_valid = 4'b0000;
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL single_early_valid: got %b want 0", bus.rsp_valid); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (bus.rsp_valid !== 1'b1) $display("FAIL single_rsp_valid: got %b want 1", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.rsp_data !== exp_data) $display("FAIL single_rsp_data: got %h want %h", bus.rsp_data, exp_data); else n_pass++;
    n_checks++; if (bus.rsp_id !== 2'(idx)) $display("FAIL single_rsp_id: got %0d want %0d", bus.rsp_id, idx); else n_pass++;
    @(posedge clk); #1;
    exp_count = exp_count + 1;
    n_checks++; if (bus.op_count !== exp_count) $display("FAIL single_op_count: got %0d want %0d", bus.op_count, exp_count); else n_pass++;
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL single_rsp_drained: got %b want 0", bus.rsp_valid); else n_pass++;
  endtask

  // All four valid for 8 cycles: grants 0,1,2,3,0,1,2,3 with no gaps.
  task automatic test_back_to_back();
    logic [3:0] er;
    load_table();
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      if (k == 8) bus.req_valid = 4'b0000;
      #1;
      er = (k < 8) ? (4'b0001 << (k % 4)) : 4'b0000;
      n_checks++; if (bus.req_ready !== er) $display("FAIL b2b_req_ready[%0d]: got %b want %b", k, bus.req_ready, er); else n_pass++;
      if (k >= 2) begin
        n_checks++; if (bus.rsp_valid !== 1'b1) $display("FAIL b2b_rsp_valid[%0d]: got %b want 1", k, bus.rsp_valid); else n_pass++;
        n_checks++; if (bus.rsp_id !== 2'((k-2) % 4)) $display("FAIL b2b_rsp_id[%0d]: got %0d want %0d", k, bus.rsp_id, (k-2) % 4); else n_pass++;
        n_checks++; if (bus.rsp_data !== prod[(k-2) % 4]) $display("FAIL b2b_rsp_data[%0d]: got %h want %h", k, bus.rsp_data, prod[(k-2) % 4]); else n_pass++;
      end
      @(posedge clk); #1;
    end
    exp_count = exp_count + 8;
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL b2b_drained: got %b want 0", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.op_count !== exp_count) $display("FAIL b2b_op_count: got %0d want %0d", bus.op_count, exp_count); else n_pass++;
  endtask

  // rsp_ready low for 6 cycles with all requesters valid, then released.
  task automatic test_backpressure();
    logic [3:0] exp_rdy [11];
    logic       exp_vld [11];
    int         exp_id  [11];
    int         accepts;
    logic [33:0] front;
    exp_rdy = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    exp_vld = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_id  = '{0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 0};
    accepts = 0;
    for (int i = 0; i < 4; i++) exp_q.push_back({2'(i), prod[i]});
    load_table();
    for (int k = 0; k < 11; k++) begin
      bus.rsp_ready = (k >= 6);
      bus.req_valid = (k < 8) ? 4'b1111 : 4'b0000;
      #1;
      n_checks++; if (bus.req_ready !== exp_rdy[k]) $display("FAIL bp_req_ready[%0d]: got %b want %b", k, bus.req_ready, exp_rdy[k]); else n_pass++;
      n_checks++; if (bus.rsp_valid !== exp_vld[k]) $display("FAIL bp_rsp_valid[%0d]: got %b want %b", k, bus.rsp_valid, exp_vld[k]); else n_pass++;
      if (exp_vld[k]) begin
        n_checks++; if (bus.rsp_id !== 2'(exp_id[k])) $display("FAIL bp_rsp_id[%0d]: got %0d want %0d", k, bus.rsp_id, exp_id[k]); else n_pass++;
        n_checks++; if (bus.rsp_data !== prod[exp_id[k]]) $display("FAIL bp_rsp_data[%0d]: got %h want %h", k, bus.rsp_data, prod[exp_id[k]]); else n_pass++;
      end
      if (k < 6) accepts += $countones(bus.req_valid & bus.req_ready);
      if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL bp_extra_rsp: got id %0d data %h want no response", bus.rsp_id, bus.rsp_data);
        end else begin
          front = exp_q.pop_front();
          n_checks++; if ({bus.rsp_id, bus.rsp_data} !== front) $display("FAIL bp_order: got %h want %h", {bus.rsp_id, bus.rsp_data}, front); else n_pass++;
        end
      end
      @(posedge clk); #1;
    end
    exp_count = exp_count + 4;
    n_checks++; if (accepts !== 2) $display("FAIL bp_accepts: got %0d want 2", accepts); else n_pass++;
    n_checks++; if (exp_q.size() !== 0) $display("FAIL bp_lost: got %0d pending want 0", exp_q.size()); else n_pass++;
    n_checks++; if (bus.op_count !== exp_count) $display("FAIL bp_op_count: got %0d want %0d", bus.op_count, exp_count); else n_pass++;
    exp_q.delete();
  endtask

  // Grant 2 moves ptr to 3; with 0 and 3 valid the order is 3 then 0.
  task automatic test_fairness_skip();
    logic [3:0] vin  [6];
    logic [3:0] erdy [6];
    logic       evld [6];
    int         eid  [6];
    vin  = '{4'b0100, 4'b1001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    erdy = '{4'b0100, 4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    evld = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    eid  = '{0, 0, 2, 3, 0, 0};
    load_table();
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.req_valid = vin[k];
      #1;
      n_checks++; if (bus.req_ready !== erdy[k]) $display("FAIL fair_req_ready[%0d]: got %b want %b", k, bus.req_ready, erdy[k]); else n_pass++;
      n_checks++; if (bus.rsp_valid !== evld[k]) $display("FAIL fair_rsp_valid[%0d]: got %b want %b", k, bus.rsp_valid, evld[k]); else n_pass++;
      if (evld[k]) begin
        n_checks++; if (bus.rsp_id !== 2'(eid[k])) $display("FAIL fair_rsp_id[%0d]: got %0d want %0d", k, bus.rsp_id, eid[k]); else n_pass++;
        n_checks++; if (bus.rsp_data !== prod[eid[k]]) $display("FAIL fair_rsp_data[%0d]: got %h want %h", k, bus.rsp_data, prod[eid[k]]); else n_pass++;
      end
      if (k == 1) begin
        n_checks++; if (bus.dbg_ptr !== 2'd3) $display("FAIL fair_ptr: got %0d want 3", bus.dbg_ptr); else n_pass++;
      end
      @(posedge clk); #1;
    end
    exp_count = exp_count + 3;
    n_checks++; if (bus.op_count !== exp_count) $display("FAIL fair_op_count: got %0d want %0d", bus.op_count, exp_count); else n_pass++;
  endtask

  // Fill S1 and S2 under backpressure, then reset mid-flight.
  task automatic test_reset_midflight();
    load_table();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1111;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++; if (bus.rsp_valid !== 1'b1) $display("FAIL rmf_full: got %b want 1", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.rsp_id !== 2'd1) $display("FAIL rmf_full_id: got %0d want 1", bus.rsp_id); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0000) $display("FAIL rmf_ready_in_rst: got %b want 0000", bus.req_ready); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL rmf_rsp_valid: got %b want 0", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.op_count !== 32'd0) $display("FAIL rmf_op_count: got %0d want 0", bus.op_count); else n_pass++;
    n_checks++; if (bus.dbg_ptr !== 2'd0) $display("FAIL rmf_ptr: got %0d want 0", bus.dbg_ptr); else n_pass++;
    rst = 1'b0;
    bus.req_valid = 4'b0110;
    bus.rsp_ready = 1'b1;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0010) $display("FAIL rmf_first_grant: got %b want 0010", bus.req_ready); else n_pass++;
    @(posedge clk); #1;
    bus.req_valid = 4'b0000;
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL rmf_no_stale: got %b want 0", bus.rsp_valid); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (bus.rsp_valid !== 1'b1) $display("FAIL rmf_rsp_valid2: got %b want 1", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.rsp_id !== 2'd1) $display("FAIL rmf_rsp_id: got %0d want 1", bus.rsp_id); else n_pass++;
    n_checks++; if (bus.rsp_data !== prod[1]) $display("FAIL rmf_rsp_data: got %h want %h", bus.rsp_data, prod[1]); else n_pass++;
    @(posedge clk); #1;
    exp_count = 32'd1;
    n_checks++; if (bus.op_count !== exp_count) $display("FAIL rmf_op_count2: got %0d want %0d", bus.op_count, exp_count); else n_pass++;
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL rmf_drained: got %b want 0", bus.rsp_valid); else n_pass++;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    exp_count = 32'd0;
    for (int i = 0; i < 4; i++) begin
      op_a[i] = {4'(i + 1), 12'hABC};
      op_b[i] = {4'(i + 2), 12'h123};
    end
    prod[0] = 32'h0200_0000;
    prod[1] = 32'h0600_0000;
    prod[2] = 32'h0C00_0000;
    prod[3] = 32'h1400_0000;
    rst           = 1'b1;
    bus.req_valid = 4'b0000;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;

    test_reset();
    test_single_op(0, 16'hF000, 16'hF000, 32'hE100_0000);
    test_single_op(1, 16'h1000, 16'h1000, 32'h0100_0000);
    test_single_op(2, 16'h0FFF, 16'hFFFF, 32'h0000_0000);
    test_single_op(3, 16'hABCD, 16'h3FFF, 32'h1E00_0000);
    test_back_to_back();
    test_backpressure();
    test_fairness_skip();
    test_reset_midflight();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mul16u_rr_arbiter.md
# mul16u_rr_arbiter

Round-robin arbiter and pipeline sequencer that shares one approximate 16x16 unsigned multiplier core among `NREQ` requesters. Each requester uses a valid/ready request channel carrying two 16-bit operands. The block issues at most one operation per cycle into a two-stage registered pipeline and returns tagged 32-bit products on a single valid/ready response channel with backpressure. It sits between accelerator lanes and the approximate-multiplier datapath, so that several lanes can reuse one low-LUT core.

## Interface
- `NREQ`, default 4, number of requesters (2..8).
- `ID_W`, default 2, width of the response tag; equals clog2(`NREQ`).
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `req_valid`  in  NREQ  per-requester operation valid.
- `req_ready`  out  NREQ  per-requester accept; one-hot or zero.
- `req_a`  in  NREQ*16  operand A; slice i belongs to requester i.
- `req_b`  in  NREQ*16  operand B; slice i belongs to requester i.
- `rsp_valid`  out  1  product valid.
- `rsp_ready`  in  1  consumer accept.
- `rsp_data`  out  32  approximate product.
- `rsp_id`  out  ID_W  index of the requester that issued the operation.
- `op_count`  out  32  number of completed response handshakes; wraps modulo 2^32.

## Operation
- **Core function:** product = {A[15:12]*B[15:12], 24'b0}. The product is exact over the top nibbles; every other bit is zero.
- **Stage S1 (operand register):** holds s1_valid, a, b, id.
- **Stage S2 (output register):** drives rsp_valid, rsp_data and rsp_id.
- **Advance conditions:**
  - s2_adv = !rsp_valid || rsp_ready.
  - s1_adv = !s1_valid || s2_adv.
  - When s2_adv is true, S2 loads the core output for S1's operands and copies S1's valid.
- **Arbitration:**
  - Pointer `ptr`, range 0..NREQ-1.
  - When s1_adv is true, grant the first i with req_valid[i], searching ptr, ptr+1, ... modulo NREQ.
  - req_ready[i] = grant[i].
  - On a grant to i: S1 loads the operands with id=i, and ptr <= (i+1) mod NREQ.
  - With no grant, S1 loads valid=0 if it is advancing, and ptr holds.
- **Ready/valid dependency:** req_ready may depend combinationally on req_valid and rsp_ready. A requester must not make req_valid depend on req_ready.
- **Request stability:** while req_valid[i]=1 and req_ready[i]=0, the requester holds its operands stable.
- **Response stability:** while rsp_valid=1 and rsp_ready=0, rsp_data and rsp_id stay stable. Nothing is dropped or duplicated.
- **Ordering:** responses come out in grant order.
- **op_count:** increments on each cycle where rsp_valid && rsp_ready, and wraps 0xFFFFFFFF -> 0.
- **Reset values:**
  - req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0.
  - ptr=0, s1_valid=0, op_count=0.
- **Reset mid-operation:** in-flight operations are discarded and produce no response. Requesters re-present their requests.
- **Simultaneous events:** in one cycle, a response handshake, an S1->S2 move and a new grant may all happen; throughput is then 1 op per cycle.

## Timing
- **Latency:** a request handshake at edge T gives rsp_valid=1 after edge T+1 (S1 at T, S2 at T+1), i.e. 2 cycles with rsp_ready held high.
- **Throughput:** 1 op per cycle sustained while rsp_ready=1.
- **Stall capacity:** with rsp_ready=0, at most 2 operations are accepted (one in S1, one in S2), then all req_ready=0.
- **Combinational path:** the only combinational path is req_valid/rsp_ready -> req_ready. The core's output is consumed only by S2.

## Structure
- **Package `mul16u_arb_pkg`:** OP_W=16, PROD_W=32, NIB_LSB=12, a default NREQ, and a typedef struct for the stage register {valid, a, b, id}.
- **Sub-module `mul16u_nib_core`:** combinational approximate multiplier (A, B -> O) with the core function above. It is instantiated once between S1 and S2, so the core can be swapped for another approximate variant.
- **Arbiter:** the round-robin find-first is a function local to `mul16u_rr_arbiter`, not a separate module.

## Test plan
1. **Single request:** req 0 with A=0xF000, B=0xF000, rsp_ready=1 -> rsp_valid 2 cycles after accept with rsp_data=0xE1000000, rsp_id=0, op_count=1.
2. **Operand values:** A=0x1000, B=0x1000 -> 0x01000000. A=0x0FFF, B=0xFFFF -> 0x00000000. A=0xABCD, B=0x3FFF -> 0x1E000000.
3. **All four requesters valid continuously, rsp_ready=1:** grants go 0,1,2,3,0,... with one req_ready per cycle; rsp_id follows the same sequence; no gap cycles.
4. **Backpressure:** rsp_ready=0 for 6 cycles with all requesters valid.
   - Exactly 2 accepts occur; rsp_data and rsp_id stay stable.
   - After release, responses drain in grant order with no loss.
5. **Fairness skip:** after a grant to 2 (ptr=3), only requesters 0 and 3 are valid -> grant 3, then 0.
6. **Reset mid-flight:** assert rst with S1 and S2 both valid.
   - Next cycle: rsp_valid=0, op_count=0, ptr=0.
   - The first grant after reset goes to the lowest valid index.
